// File: rtl/trace_output_serialiser_pkg.sv
`default_nettype none
// ============================================================================
// Module   : trace_output_serialiser_pkg
// Brief    : Shared datatypes for the trace output path: record layout,
//            serialiser constants, FSM states and the word-select helper.
// Revision : 1.0 - initial release
// ============================================================================
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

package trace_output_serialiser_pkg;

    localparam logic [7:0] c_HEADER_SYNC = 8'hA5;
    localparam int         c_WORD_COUNT  = 19;
    localparam logic [4:0] c_LAST_INDEX  = 5'(c_WORD_COUNT - 1);

    typedef struct packed {
        logic [31:0] start_time;
        logic [31:0] end_time;
    } mem_access_req;

    typedef struct packed {
        logic [31:0] start_time;
        logic [31:0] end_time;
    } mem_access_res;

    typedef struct packed {
        logic [31:0]   time_start;
        logic [31:0]   time_end;
        mem_access_req req;
        mem_access_res res;
    } IF_data;

    typedef struct packed {
        logic [31:0] start_time;
        logic [31:0] end_time;
    } ID_data;

    typedef struct packed {
        logic [31:0]   start_time;
        logic [31:0]   end_time;
        mem_access_req req;
    } EX_data;

    typedef struct packed {
        logic [31:0]   start_time;
        logic [31:0]   end_time;
        mem_access_res res;
    } WB_data;

    typedef struct packed {
        logic        pass_through;
        logic [31:0] instruction;
        logic [31:0] addr;
        IF_data      if_d;
        ID_data      id_d;
        EX_data      ex_d;
        WB_data      wb_d;
    } trace_output;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } ser_state_t;

    // Word idx of a record in wire order; index 0 is the header.
    function automatic logic [`DATA_WIDTH-1:0] select_word(
        input trace_output rec,
        input logic [4:0]  idx,
        input logic [15:0] seq
    );
        logic [`DATA_WIDTH-1:0] w;
        case (idx)
            5'd0:    w = {c_HEADER_SYNC, 7'd0, rec.pass_through, seq};
            5'd1:    w = rec.instruction;
            5'd2:    w = rec.addr;
            5'd3:    w = rec.if_d.time_start;
            5'd4:    w = rec.if_d.time_end;
            5'd5:    w = rec.if_d.req.start_time;
            5'd6:    w = rec.if_d.req.end_time;
            5'd7:    w = rec.if_d.res.start_time;
            5'd8:    w = rec.if_d.res.end_time;
            5'd9:    w = rec.id_d.start_time;
            5'd10:   w = rec.id_d.end_time;
            5'd11:   w = rec.ex_d.start_time;
            5'd12:   w = rec.ex_d.end_time;
            5'd13:   w = rec.ex_d.req.start_time;
            5'd14:   w = rec.ex_d.req.end_time;
            5'd15:   w = rec.wb_d.start_time;
            5'd16:   w = rec.wb_d.end_time;
            5'd17:   w = rec.wb_d.res.start_time;
            5'd18:   w = rec.wb_d.res.end_time;
            default: w = '0;
        endcase
        return w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/trace_output_serialiser_fifo.sv
`default_nettype none
// ============================================================================
// Module   : trace_record_fifo
// Brief    : Small FIFO of complete trace records. Pointers carry one extra
//            wrap bit so full and empty are distinguished without a counter.
// Revision : 1.0 - initial release
// ============================================================================
module trace_record_fifo
    import trace_output_serialiser_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    push_i,
    input  trace_output             data_i,
    input  logic                    pop_i,
    output trace_output             data_o,
    output logic                    full_o,
    output logic                    empty_o,
    output logic [$clog2(DEPTH):0]  count_o
);

    localparam int          AW           = $clog2(DEPTH);
    localparam logic [AW:0] c_FULL_COUNT = (AW + 1)'(DEPTH);
    localparam logic [AW:0] c_PTR_ONE    = (AW + 1)'(1);

    trace_output mem_q [DEPTH];
    trace_output mem_d [DEPTH];
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic        w_do_push;
    logic        w_do_pop;

    assign count_o   = wr_ptr_q - rd_ptr_q;
    assign full_o    = (count_o == c_FULL_COUNT);
    assign empty_o   = (count_o == '0);
    assign w_do_push = push_i & ~full_o;
    assign w_do_pop  = pop_i & ~empty_o;
    assign data_o    = mem_q[rd_ptr_q[AW-1:0]];

    // Write the incoming record and advance whichever pointers moved.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (w_do_push) begin
            mem_d[wr_ptr_q[AW-1:0]] = data_i;
            wr_ptr_d                = wr_ptr_q + c_PTR_ONE;
        end
        if (w_do_pop) begin
            rd_ptr_d = rd_ptr_q + c_PTR_ONE;
        end
    end

    // Pointer registers; clearing them empties the FIFO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Record storage; contents are only meaningful behind valid pointers.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

`default_nettype wire

// File: rtl/trace_output_serialiser.sv
`default_nettype none
// ============================================================================
// Module   : trace_output_serialiser
// Brief    : Buffers trace records and streams each one as a 19-word burst
//            (header + 18 data words) over a valid/ready word interface.
// Revision : 1.0 - initial release
// ============================================================================
module trace_output_serialiser
    import trace_output_serialiser_pkg::*;
#(
    parameter int FIFO_DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  trace_output            trace_i,
    input  logic                   trace_valid_i,
    output logic                   trace_ready_o,
    output logic [`DATA_WIDTH-1:0] word_o,
    output logic                   word_valid_o,
    input  logic                   word_ready_i,
    output logic                   word_last_o
);

    localparam int               CW      = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0]    c_ONE   = CW'(1);

    ser_state_t    state_q, state_d;
    logic [4:0]    idx_q, idx_d;
    logic [15:0]   seq_q, seq_d;
    logic          ready_en_q, ready_en_d;

    trace_output   w_head;
    logic          w_full;
    logic          w_empty;
    logic [CW-1:0] w_count;
    logic          w_push;
    logic          w_word_hs;
    logic          w_last;
    logic          w_pop;

    // ready_en_q keeps the input closed until the first edge out of reset.
    assign trace_ready_o = ready_en_q & ~w_full;
    assign w_push        = trace_valid_i & trace_ready_o;
    assign word_valid_o  = (state_q == ST_SEND);
    assign w_last        = (state_q == ST_SEND) && (idx_q == c_LAST_INDEX);
    assign word_last_o   = w_last;
    assign w_word_hs     = word_valid_o & word_ready_i;
    assign w_pop         = w_word_hs & w_last;
    assign word_o        = (state_q == ST_SEND) ? select_word(w_head, idx_q, seq_q) : '0;

    trace_record_fifo #(
        .DEPTH   (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (w_push),
        .data_i  (trace_i),
        .pop_i   (w_pop),
        .data_o  (w_head),
        .full_o  (w_full),
        .empty_o (w_empty),
        .count_o (w_count)
    );

    // Next-state: enter SEND on the accept edge so the header appears one
    // cycle later; on the last word either chain into the next record or idle.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        seq_d      = seq_q;
        ready_en_d = 1'b1;
        case (state_q)
            ST_IDLE: begin
                if (w_push || !w_empty) begin
                    state_d = ST_SEND;
                    idx_d   = 5'd0;
                end
            end
            ST_SEND: begin
                if (w_word_hs) begin
                    if (w_last) begin
                        idx_d = 5'd0;
                        seq_d = seq_q + 16'd1;
                        if ((w_count > c_ONE) || w_push) begin
                            state_d = ST_SEND;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        idx_d = idx_q + 5'd1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = 5'd0;
            end
        endcase
    end

    // Control registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            idx_q      <= 5'd0;
            seq_q      <= 16'd0;
            ready_en_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            seq_q      <= seq_d;
            ready_en_q <= ready_en_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_trace_output_serialiser.sv
`default_nettype none
// ============================================================================
// Module   : tb_trace_output_serialiser
// Brief    : Directed bench with a word scoreboard for trace_output_serialiser.
// Revision : 1.0 - initial release
// ============================================================================
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module tb_trace_output_serialiser;
    import trace_output_serialiser_pkg::*;

    logic                   clk = 1'b0;
    logic                   rst_n;
    trace_output            trace_i;
    logic                   trace_valid_i;
    logic                   trace_ready_o;
    logic [`DATA_WIDTH-1:0] word_o;
    logic                   word_valid_o;
    logic                   word_ready_i;
    logic                   word_last_o;

    int          checks = 0;
    int          errors = 0;
    logic [32:0] exp_q[$];
    logic [15:0] model_seq = 16'd0;
    int          cyc = 0;
    int          hs_count = 0;
    int          rec_hs = 0;
    int          first_cyc = 0;
    int          last_cyc = 0;
    logic        mark_first = 1'b0;

    always #5 clk = ~clk;

    trace_output_serialiser #(
        .FIFO_DEPTH    (2)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .trace_i       (trace_i),
        .trace_valid_i (trace_valid_i),
        .trace_ready_o (trace_ready_o),
        .word_o        (word_o),
        .word_valid_o  (word_valid_o),
        .word_ready_i  (word_ready_i),
        .word_last_o   (word_last_o)
    );

    // Output monitor: scoreboard compare on every handshake and stall stability.
    initial begin : monitor
        logic        stall_prev;
        logic [31:0] stall_word;
        logic        stall_last;
        logic [32:0] exp;
        stall_prev = 1'b0;
        stall_word = '0;
        stall_last = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst_n !== 1'b1) begin
                stall_prev = 1'b0;
                rec_hs     = 0;
            end else begin
                if (stall_prev) begin
                    checks++;
                    assert (word_valid_o === 1'b1 && word_o === stall_word && word_last_o === stall_last)
                    else begin
                        errors++;
                        $error("FAIL stall_hold observed v=%b w=%h l=%b expected v=1 w=%h l=%b",
                               word_valid_o, word_o, word_last_o, stall_word, stall_last);
                    end
                end
                if (word_valid_o === 1'b1 && word_ready_i === 1'b1) begin
                    checks++;
                    assert (exp_q.size() != 0)
                    else begin
                        errors++;
                        $error("FAIL unexpected_word observed %h last=%b expected none", word_o, word_last_o);
                    end
                    if (exp_q.size() != 0) begin
                        exp = exp_q.pop_front();
                        checks++;
                        assert ({word_last_o, word_o} === exp)
                        else begin
                            errors++;
                            $error("FAIL word observed last=%b w=%h expected last=%b w=%h",
                                   word_last_o, word_o, exp[32], exp[31:0]);
                        end
                    end
                    if (mark_first) begin
                        first_cyc  = cyc;
                        mark_first = 1'b0;
                    end
                    last_cyc = cyc;
                    hs_count++;
                    rec_hs = (word_last_o === 1'b1) ? 0 : rec_hs + 1;
                end
                stall_prev = (word_valid_o === 1'b1) && (word_ready_i !== 1'b1);
                stall_word = word_o;
                stall_last = word_last_o;
            end
        end
    end

    // Drive one record whose 16 timing fields are base..base+15 and queue
    // the 19 words it must produce.
    task automatic push_rec(input logic pt, input logic [31:0] instr,
                            input logic [31:0] addr, input logic [31:0] base);
        trace_output r;
        int          waitc;
        r.pass_through         = pt;
        r.instruction          = instr;
        r.addr                 = addr;
        r.if_d.time_start      = base + 0;
        r.if_d.time_end        = base + 1;
        r.if_d.req.start_time  = base + 2;
        r.if_d.req.end_time    = base + 3;
        r.if_d.res.start_time  = base + 4;
        r.if_d.res.end_time    = base + 5;
        r.id_d.start_time      = base + 6;
        r.id_d.end_time        = base + 7;
        r.ex_d.start_time      = base + 8;
        r.ex_d.end_time        = base + 9;
        r.ex_d.req.start_time  = base + 10;
        r.ex_d.req.end_time    = base + 11;
        r.wb_d.start_time      = base + 12;
        r.wb_d.end_time        = base + 13;
        r.wb_d.res.start_time  = base + 14;
        r.wb_d.res.end_time    = base + 15;
        trace_i       = r;
        trace_valid_i = 1'b1;
        waitc         = 0;
        @(negedge clk);
        while (trace_ready_o !== 1'b1 && waitc < 400) begin
            @(negedge clk);
            waitc++;
        end
        checks++;
        assert (trace_ready_o === 1'b1)
        else begin
            errors++;
            $error("FAIL push_timeout observed ready=%b expected 1", trace_ready_o);
        end
        exp_q.push_back({1'b0, 8'hA5, 7'd0, pt, model_seq});
        exp_q.push_back({1'b0, instr});
        exp_q.push_back({1'b0, addr});
        for (int k = 0; k < 16; k++) begin
            exp_q.push_back({(k == 15), base + 32'(k)});
        end
        model_seq = model_seq + 16'd1;
        @(posedge clk);
        #1;
        trace_valid_i = 1'b0;
    endtask

    // Wait (bounded) for the scoreboard to empty.
    task automatic wait_drain(input string tag);
        int waitc;
        waitc = 0;
        while (exp_q.size() != 0 && waitc < 2000) begin
            @(posedge clk);
            waitc++;
        end
        #1;
        checks++;
        assert (exp_q.size() == 0)
        else begin
            errors++;
            $error("FAIL %s_drain observed %0d words outstanding expected 0", tag, exp_q.size());
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        exp_q.delete();
        model_seq = 16'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int hs_before;
        rst_n         = 1'b0;
        trace_valid_i = 1'b0;
        trace_i       = '0;
        word_ready_i  = 1'b1;

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        assert (trace_ready_o === 1'b0) else begin errors++; $error("FAIL rst_ready observed %b expected 0", trace_ready_o); end
        checks++;
        assert (word_valid_o === 1'b0) else begin errors++; $error("FAIL rst_valid observed %b expected 0", word_valid_o); end
        checks++;
        assert (word_last_o === 1'b0) else begin errors++; $error("FAIL rst_last observed %b expected 0", word_last_o); end
        checks++;
        assert (word_o === 32'h0) else begin errors++; $error("FAIL rst_word observed %h expected 0", word_o); end
        #2;
        rst_n = 1'b1;
        #1;
        checks++;
        assert (trace_ready_o === 1'b0) else begin errors++; $error("FAIL ready_pre_edge observed %b expected 0", trace_ready_o); end
        @(posedge clk);
        #1;
        checks++;
        assert (trace_ready_o === 1'b1) else begin errors++; $error("FAIL ready_first_edge observed %b expected 1", trace_ready_o); end

        // Single record, sink always ready.
        push_rec(1'b1, 32'h00500093, 32'h00000080, 32'd1);
        checks++;
        assert (word_valid_o === 1'b1 && word_o === 32'hA5010000)
        else begin errors++; $error("FAIL header_latency observed v=%b w=%h expected v=1 w=a5010000", word_valid_o, word_o); end
        wait_drain("single");

        // Three back-to-back records from sequence 0.
        do_reset();
        mark_first = 1'b1;
        hs_before  = hs_count;
        push_rec(1'b0, 32'h11111111, 32'h00000100, 32'd100);
        push_rec(1'b1, 32'h22222222, 32'h00000200, 32'd200);
        checks++;
        assert (trace_ready_o === 1'b0) else begin errors++; $error("FAIL full_ready observed %b expected 0", trace_ready_o); end
        push_rec(1'b0, 32'h33333333, 32'h00000300, 32'd300);
        wait_drain("b2b");
        checks++;
        assert (hs_count - hs_before == 57) else begin errors++; $error("FAIL b2b_count observed %0d expected 57", hs_count - hs_before); end
        checks++;
        assert (last_cyc - first_cyc == 56) else begin errors++; $error("FAIL b2b_gapless observed span %0d expected 56", last_cyc - first_cyc); end

        // Random sink stalls.
        fork
            begin
                push_rec(1'b1, 32'hAAAA0001, 32'h00001000, 32'd1000);
                push_rec(1'b0, 32'hAAAA0002, 32'h00002000, 32'd2000);
                push_rec(1'b1, 32'hAAAA0003, 32'h00003000, 32'd3000);
                push_rec(1'b0, 32'hAAAA0004, 32'h00004000, 32'd4000);
            end
            begin
                for (int i = 0; i < 300; i++) begin
                    @(posedge clk);
                    #1;
                    word_ready_i = 1'($urandom_range(0, 1));
                end
                word_ready_i = 1'b1;
            end
        join
        wait_drain("stall");

        // Sequence wrap.
        repeat (3) @(posedge clk);
        @(negedge clk);
        force dut.seq_q = 16'hFFFF;
        @(posedge clk);
        #1;
        release dut.seq_q;
        model_seq = 16'hFFFF;
        push_rec(1'b0, 32'hBBBB0001, 32'h00005000, 32'd5000);
        checks++;
        assert (word_o[15:0] === 16'hFFFF) else begin errors++; $error("FAIL seq_ffff observed %h expected ffff", word_o[15:0]); end
        push_rec(1'b1, 32'hBBBB0002, 32'h00006000, 32'd6000);
        wait_drain("wrap");

        // Reset mid-record with a second record queued.
        do_reset();
        push_rec(1'b1, 32'hCCCC0001, 32'h00007000, 32'd7000);
        push_rec(1'b1, 32'hCCCC0002, 32'h00008000, 32'd8000);
        begin : wait_idx7
            int waitc;
            waitc = 0;
            while (rec_hs != 7 && waitc < 200) begin
                @(posedge clk);
                waitc++;
            end
        end
        #2;
        checks++;
        assert (word_o === 32'd7004) else begin errors++; $error("FAIL idx7_word observed %h expected %h", word_o, 32'd7004); end
        rst_n = 1'b0;
        exp_q.delete();
        model_seq = 16'd0;
        #1;
        checks++;
        assert (trace_ready_o === 1'b0 && word_valid_o === 1'b0 && word_last_o === 1'b0 && word_o === 32'h0)
        else begin
            errors++;
            $error("FAIL midrst_outputs observed r=%b v=%b l=%b w=%h expected all 0",
                   trace_ready_o, word_valid_o, word_last_o, word_o);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        assert (trace_ready_o === 1'b1) else begin errors++; $error("FAIL ready_after_rst observed %b expected 1", trace_ready_o); end
        push_rec(1'b0, 32'hDDDD0001, 32'h00009000, 32'd9000);
        checks++;
        assert (word_valid_o === 1'b1 && word_o === 32'hA5000000)
        else begin errors++; $error("FAIL header_after_rst observed v=%b w=%h expected v=1 w=a5000000", word_valid_o, word_o); end
        wait_drain("post_rst");
        repeat (40) @(posedge clk);
        #1;
        checks++;
        assert (word_valid_o === 1'b0) else begin errors++; $error("FAIL idle_after_drain observed %b expected 0", word_valid_o); end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/trace_output_serialiser.md
TRACE_OUTPUT_SERIALISER -- requirements
Module: trace_output_serialiser

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 2, meaning the number of trace_output records buffered (power of two, >=2).
REQ-002 SHALL have port clk  input  1  sole clock, all state on the rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port trace_i  input  $bits(trace_output)  trace record from the tracer.
REQ-005 SHALL have port trace_valid_i  input  1  trace_i is valid this cycle.
REQ-006 SHALL have port trace_ready_o  output  1  the block accepts trace_i this cycle.
REQ-007 SHALL have port word_o  output  `DATA_WIDTH  current serial word.
REQ-008 SHALL have port word_valid_o  output  1  word_o is valid.
REQ-009 SHALL have port word_ready_i  input  1  the sink accepts word_o.
REQ-010 SHALL have port word_last_o  output  1  word_o is the final word of a record.

Function
REQ-011 SHALL accept a record on any rising edge where trace_valid_i and trace_ready_o are both high.
REQ-012 SHALL drive trace_ready_o = FIFO not full; it SHALL NOT depend combinationally on word_ready_i.
REQ-013 SHALL emit each record as exactly 19 words in this order: header, instruction, addr, IF time_start, IF time_end, IF req start, IF req end, IF res start, IF res end, ID start, ID end, EX start, EX end, EX req start, EX req end, WB start, WB end, WB res start, WB res end.
REQ-014 SHALL format the header as: [31:24] = 8'hA5, [23:17] = 0, [16] = pass_through, [15:0] = sequence number.
REQ-015 SHALL hold the sequence number in a 16-bit counter, reset to 0, incremented after each word_last_o handshake, wrapping from 16'hFFFF to 16'h0000.
REQ-016 SHALL transfer a word on every rising edge where word_valid_o and word_ready_i are both high.
REQ-017 SHALL hold word_o, word_last_o and word_valid_o stable while word_valid_o is high and word_ready_i is low.
REQ-018 SHALL use a two-state FSM: IDLE (FIFO empty, word_valid_o low) and SEND (word_valid_o high, 5-bit word index 0..18).
REQ-019 SHALL move from IDLE to SEND with index 0 on the first edge the FIFO is non-empty.
REQ-020 SHALL increment the index on each word handshake in SEND.
REQ-021 SHALL, on the handshake at index 18, pop the FIFO and then either return to IDLE (FIFO now empty) or stay in SEND with index 0 (more records queued), with no bubble cycle.
REQ-022 SHALL assert word_last_o only when in SEND and index = 18.
REQ-023 SHALL present the header word at the cycle after the edge that accepted a record into an empty FIFO (1-cycle latency).
REQ-024 SHALL, on a simultaneous push and pop when full, keep trace_ready_o low for that cycle; the pop frees a slot for the next cycle.
REQ-025 SHALL, on a simultaneous push and pop when not full, keep the occupancy unchanged and preserve FIFO order.
REQ-026 SHALL NOT lose, reorder or duplicate records under any valid/ready pattern.

Reset
REQ-027 SHALL, while rst_n is low, force: trace_ready_o = 0, word_valid_o = 0, word_last_o = 0, word_o = 0, FSM = IDLE, index = 0, sequence = 0, FIFO empty.
REQ-028 SHALL, on reset assertion mid-record, discard the partial record and all queued records; the next record after reset SHALL start with a header carrying sequence 0.
REQ-029 SHALL drive trace_ready_o high on the first edge after rst_n deasserts.

Structure
REQ-030 SHALL use the trace_output, IF_data, ID_data, EX_data, WB_data, mem_access_req and mem_access_res types from the shared datatypes package.
REQ-031 SHALL define the header sync constant 8'hA5 and the word count 19 in the shared datatypes package.
REQ-032 SHALL place record storage in one sub-module, trace_record_fifo, holding full records with push/pop/full/empty signals and registered storage.

Verification
REQ-033 SHALL cover: one record with instruction 32'h00500093, addr 32'h00000080, pass_through 1, and IF time_start..WB res end = 1..16, with word_ready_i held high -> header 32'hA5010000 at accept+1, then the 18 data words in REQ-013 order on consecutive cycles, and word_last_o only on the word equal to 16.
REQ-034 SHALL cover: 3 back-to-back records -> 57 words with no gaps, headers carrying sequence 0, 1 and 2, and trace_ready_o low after the FIFO fills.
REQ-035 SHALL cover: word_ready_i toggling on a pseudo-random 50% pattern -> word_o stable while stalled and the output stream identical to the no-stall stream.
REQ-036 SHALL cover: preloading the sequence to 16'hFFFF (send 65535 records, or force the counter) -> next header [15:0] = 16'hFFFF, and the following header = 16'h0000.
REQ-037 SHALL cover: rst_n pulsed low at word index 7 of a record with a second record queued -> all outputs 0 immediately, and after release a new record emits header 32'hA5000000 (pass_through 0, sequence 0).
